// File: rtl/lsu_mem_port.sv
// Memory-side responder for the load/store path: an in-order request queue
// issued one entry at a time to data memory, with tagged load/store completion.
module lsu_mem_port #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_en,
    input  logic [15:0]      mem_addr,
    input  logic             mem_wr,
    input  logic [15:0]      mem_wdata,
    input  logic [TAG_W-1:0] mem_tag,
    input  logic             flush,
    output logic             mem_free,
    output logic             dm_req,
    output logic             dm_we,
    output logic [15:0]      dm_addr,
    output logic [15:0]      dm_wdata,
    input  logic             dm_ack,
    input  logic [15:0]      dm_rdata,
    output logic             ld_valid,
    output logic [TAG_W-1:0] ld_tag,
    output logic [15:0]      ld_data,
    output logic             st_done,
    output logic [TAG_W-1:0] st_tag,
    output logic             dbg_state
);

    // Handshakes: a request enters at a rising edge where mem_en & mem_free & ~flush;
    // a memory request is held stable while dm_req=1 and completes at the edge where dm_ack=1.

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t            state;
    logic              killed;
    logic [TAG_W-1:0]  cur_tag;

    logic              q_wr    [DEPTH];
    logic [15:0]       q_addr  [DEPTH];
    logic [15:0]       q_wdata [DEPTH];
    logic [TAG_W-1:0]  q_tag   [DEPTH];

    logic [AW-1:0]     rptr, wptr, rptr_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic              push, pop;

    logic              hd_wr;
    logic [15:0]       hd_addr;
    logic [15:0]       hd_wdata;
    logic [TAG_W-1:0]  hd_tag;

    assign mem_free  = (count < FULL);
    assign push      = mem_en & mem_free & ~flush;
    assign pop       = (state == S_REQ) & dm_ack & ~killed;
    assign rptr_nxt  = rptr + AW'(1);
    assign dbg_state = (state == S_REQ);

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // In IDLE the head is at rptr. In REQ the in-flight entry is at rptr, so the next
    // head is rptr+1, or the entry being enqueued this same cycle when only one is queued.
    always_comb begin
        hd_wr    = q_wr[rptr];
        hd_addr  = q_addr[rptr];
        hd_wdata = q_wdata[rptr];
        hd_tag   = q_tag[rptr];
        if (state == S_REQ) begin
            if (count > CW'(1)) begin
                hd_wr    = q_wr[rptr_nxt];
                hd_addr  = q_addr[rptr_nxt];
                hd_wdata = q_wdata[rptr_nxt];
                hd_tag   = q_tag[rptr_nxt];
            end else begin
                hd_wr    = mem_wr;
                hd_addr  = mem_addr;
                hd_wdata = mem_wdata;
                hd_tag   = mem_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_wr[wptr]    <= mem_wr;
            q_addr[wptr]  <= mem_addr;
            q_wdata[wptr] <= mem_wdata;
            q_tag[wptr]   <= mem_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr_nxt;
            count <= count_nxt;
        end
    end

    // A request already in flight at a flush finishes its handshake but is marked
    // killed: it no longer occupies the queue and produces no completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            killed   <= 1'b0;
            cur_tag  <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            ld_valid <= 1'b0;
            ld_tag   <= '0;
            ld_data  <= '0;
            st_done  <= 1'b0;
            st_tag   <= '0;
        end else begin
            ld_valid <= 1'b0;
            st_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (count != '0 && !flush) begin
                        state    <= S_REQ;
                        killed   <= 1'b0;
                        dm_req   <= 1'b1;
                        dm_we    <= hd_wr;
                        dm_addr  <= hd_addr;
                        dm_wdata <= hd_wdata;
                        cur_tag  <= hd_tag;
                    end
                end
                S_REQ: begin
                    if (dm_ack) begin
                        if (!killed && !flush) begin
                            if (dm_we) begin
                                st_done <= 1'b1;
                                st_tag  <= cur_tag;
                            end else begin
                                ld_valid <= 1'b1;
                                ld_tag   <= cur_tag;
                                ld_data  <= dm_rdata;
                            end
                        end
                        if (pop && count_nxt != '0 && !flush) begin
                            dm_we    <= hd_wr;
                            dm_addr  <= hd_addr;
                            dm_wdata <= hd_wdata;
                            cur_tag  <= hd_tag;
                        end else begin
                            state  <= S_IDLE;
                            dm_req <= 1'b0;
                            killed <= 1'b0;
                        end
                    end else if (flush) begin
                        killed <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    dm_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Memory-side responder for the load/store path. It accepts effective addresses from the address adder together with the op type, store data and destination tag. Requests are buffered in a small in-order queue and issued one at a time to the data memory over a req/ack handshake. Load data is returned with its tag, and store completion is reported with its tag. It sits between the address adder and the data memory, and back-pressures issue through `mem_free`.

## Interface
- `DEPTH`, 4: queue entries (power of two, ≥2)
- `TAG_W`, 6: width of the ROB/destination tag
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `mem_en` in 1: request valid this cycle (address adder output valid)
- `mem_addr` in 16: effective address (address adder sum)
- `mem_wr` in 1: 1 = store, 0 = load
- `mem_wdata` in 16: store data (ignored for loads)
- `mem_tag` in TAG_W: tag of the issuing instruction
- `flush` in 1: discard all queued, not-yet-issued requests
- `mem_free` out 1: queue can accept a request this cycle
- `dm_req` out 1: data memory request
- `dm_we` out 1: write enable for the current request
- `dm_addr` out 16: address for the current request
- `dm_wdata` out 16: write data for the current request
- `dm_ack` in 1: memory accepted/completed the request; `dm_rdata` is valid in the same cycle for loads
- `dm_rdata` in 16: load data from memory
- `ld_valid` out 1: one-cycle pulse, load result valid
- `ld_tag` out TAG_W: tag of the completed load
- `ld_data` out 16: load result
- `st_done` out 1: one-cycle pulse, store written
- `st_tag` out TAG_W: tag of the completed store

## Operation
- **Queue.** Circular FIFO of DEPTH entries holding {wr, addr, wdata, tag}, with a read pointer, a write pointer and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- `mem_free` = (count < DEPTH), derived from the registered count only. A pop in the same cycle does not make a full queue accept.
- **Enqueue.** Occurs at the edge where `mem_en` & `mem_free` & ~`flush`. `mem_en` while full is ignored: no write, and the pointers do not move.
- **FSM states.**
  - IDLE: `dm_req` = 0. If count > 0, load the `dm_*` registers from the head entry and go to REQ.
  - REQ: `dm_req` = 1. Hold `dm_we`, `dm_addr` and `dm_wdata` stable until `dm_ack`.
  - On `dm_ack` in REQ: pop the head. If count after the pop is > 0 and there is no flush, load the next head and stay in REQ (back-to-back issue). Otherwise go to IDLE.
- **Completion.** On the `dm_ack` edge, a load registers `ld_valid`=1, `ld_tag`=entry tag and `ld_data`=`dm_rdata`. A store registers `st_done`=1 and `st_tag`=entry tag. Each pulse lasts exactly one cycle. `ld_data` and the tags hold their last value when the pulse is low.
- **Flush.**
  - At the flush edge, count and the pointers are cleared for all entries except an entry that is already in REQ.
  - That in-flight request completes its handshake normally. Stores still write; its `ld_valid`/`st_done` pulse is suppressed.
  - After `dm_ack`, the FSM goes to IDLE.
  - A simultaneous `mem_en` is dropped.
- **Simultaneous enqueue and pop.** Count is unchanged. Both pointers advance.
- `dm_ack` outside REQ is ignored.
- **Reset.** Asynchronous. It clears the state to IDLE, count and pointers to 0, and all outputs to 0 except `mem_free`, which is 1. A transaction in flight is abandoned, and no completion pulse is produced.

## Timing
- Minimum latency: request enqueued at edge E0 → `dm_req` high after E1. With `dm_ack` high in that cycle, the pop happens at E2 and `ld_valid`/`st_done` are high in the cycle after E2.
- Sustained throughput: one request per cycle while memory acks every cycle and the queue is non-empty.
- The `dm_*` outputs and the completion outputs are registered. `mem_free` depends only on registers.
- Memory wait states: `dm_ack` low for k cycles extends REQ by k cycles. The `dm_*` outputs stay constant throughout.

## Test plan
- **Single load.** After reset, `mem_en`=1, `mem_wr`=0, addr=0x1234, tag=5, with `dm_ack` tied high and `dm_rdata`=0xBEEF. Required: `dm_req` high one cycle later with `dm_addr`=0x1234 and `dm_we`=0, then `ld_valid` pulses once with `ld_tag`=5 and `ld_data`=0xBEEF.
- **Fill to full.** 4 requests with `dm_ack` held low. Required: `mem_free`=0 after the 4th. A 5th `mem_en` (tag 9) is never issued. Releasing `dm_ack` completes tags in order 0,1,2,3, and `mem_free` returns to 1 after the first pop.
- **Wait states.** Store addr=0x00FF, data=0xA5A5, tag=3, with `dm_ack` delayed 3 cycles. Required: `dm_req`, `dm_we`=1, `dm_addr` and `dm_wdata` are stable for 4 cycles, then `st_done` pulses with `st_tag`=3.
- **Back-to-back and wrap.** 10 alternating load/store requests, one per cycle, with `dm_ack` always high. Required: `dm_req` is never deasserted between requests, the pointers wrap, and all 10 tags complete in order.
- **Flush mid-flight.** 3 requests are queued and the first is in REQ with `dm_ack` low. Pulse `flush`. Required: the first request still completes its handshake with no completion pulse, the others are never issued, and count returns to 0.
- **Reset mid-operation.** Assert `rst_n`=0 while in REQ. Required: `dm_req`=0 and `mem_free`=1 immediately (asynchronously), with no `ld_valid`/`st_done` pulses after reset is released.
